stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Sequencing controller for the stopwatch display path: owns the BCD minutes/seconds count and the run/pause/adjust mode, driven by conditioned push-buttons and switches.
- Outputs feed the display module's minutes/seconds inputs directly, plus a per-digit blank mask for adjust-mode blinking.
- Tick inputs are one-cycle enable strobes in the clk domain; this block owns no clocks.

Parameters:
- DB_CYCLES, 500000, cycles a button input must stay stable before its filtered level changes (5 ms at 100 MHz).
- DB_W, 20, width of the debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset; all state clears while low.
- tick_1hz  in  1  one-cycle strobe, 1 Hz; advances count in RUN.
- tick_2hz  in  1  one-cycle strobe, 2 Hz; adjust increment and blink phase.
- btn_pause  in  1  raw pause/run push-button, active-high, asynchronous.
- btn_reset  in  1  raw clear push-button, active-high, asynchronous.
- sw_adj  in  1  raw adjust-mode switch level.
- sw_sel  in  1  raw field select: 0 = minutes, 1 = seconds.
- minutes  out  8  BCD minutes {tens, ones}, 00-99.
- seconds  out  8  BCD seconds {tens, ones}, 00-59.
- blank  out  4  per-digit blank, bit3 = minutes tens ... bit0 = seconds ones.
- running  out  1  high only in RUN.

Behaviour:
- Reset (rst low): minutes = 8'h00, seconds = 8'h00, blank = 4'b0000, running = 0, state = IDLE, blink_phase = 0, synchronizers and debounce counters cleared.
- Input conditioning:
  - Every raw input passes through a 2-flop synchronizer.
  - Buttons are additionally debounced: the filtered level changes after DB_CYCLES consecutive cycles of a stable, differing synchronized value.
  - A one-cycle press pulse is emitted on the filtered level's rising edge.
  - Switches are synchronized only.
- States: IDLE, RUN, PAUSED, ADJUST. Event priority per cycle: rst > press_reset > sw_adj level > press_pause > tick.
- IDLE:
  - Time held at 00:00.
  - press_pause -> RUN.
  - sw_adj = 1 -> ADJUST.
- RUN:
  - Each tick_1hz adds one second in BCD: seconds ones 9->0 carries to tens; seconds 59->00 carries to minutes; minutes 99:59 -> 00:00 wraps, stays RUN.
  - press_pause -> PAUSED.
  - A tick_1hz in the same cycle as press_pause is still applied.
- PAUSED:
  - Time held.
  - press_pause -> RUN.
  - sw_adj = 1 -> ADJUST.
- ADJUST:
  - Counting stopped; press_pause ignored.
  - Each tick_2hz toggles blink_phase.
  - Each tick_2hz with the increment qualifier also adds 1 to the selected field: sw_sel = 0 -> minutes 99->00; sw_sel = 1 -> seconds 59->00, no carry into minutes.
  - Increment qualifier: fires on every second tick_2hz, when blink_phase goes 1->0, giving a 1 Hz step rate.
  - sw_adj = 0 -> PAUSED, with blink_phase cleared to 0.
  - sw_adj = 1 while in RUN -> ADJUST next cycle; any pending tick_1hz in that cycle is dropped.
- press_reset from any state:
  - Time -> 00:00 in the next cycle.
  - State -> IDLE, except ADJUST stays ADJUST.
  - A same-cycle tick_1hz is dropped.
- blank:
  - Registered; equals 4'b1100 (sw_sel = 0) or 4'b0011 (sw_sel = 1) when state = ADJUST and blink_phase = 1.
  - Otherwise 4'b0000.
- Latency:
  - All outputs are registered.
  - A tick takes effect on minutes/seconds one cycle after the strobe.
  - A raw button edge yields a state change DB_CYCLES+3 cycles later (2 sync + filter + edge).
- BCD invariant: no nibble ever exceeds 9; seconds tens never exceeds 5. Verification asserts this every cycle.
- rst asserted mid-count or mid-debounce: immediate clear, no partial press pulse after release.

Decomposition:
- Shared package stopwatch_pkg holds:
  - State enum (IDLE, RUN, PAUSED, ADJUST).
  - BCD limits SEC_MAX = 8'h59, MIN_MAX = 8'h99.
  - Blank mask constants BLANK_MIN = 4'b1100, BLANK_SEC = 4'b0011.
- One sub-module, btn_debounce: synchronizer, DB_CYCLES stable counter and rising-edge pulse. Instantiated twice, for pause and reset.
- BCD increment is a local function, not a module.

Test Plan (run with DB_CYCLES = 4, DB_W = 3):
- Reset release, press pause, issue 75 tick_1hz -> running = 1, minutes = 8'h01, seconds = 8'h15.
- Preload 99:59 via adjust, then RUN, one tick_1hz -> 00:00 next cycle, still RUN.
- Button bounce: btn_pause toggles every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one state change, IDLE->RUN.
- Adjust: from PAUSED at 00:58, sw_adj = 1, sw_sel = 1, 8 tick_2hz -> seconds = 8'h02, minutes unchanged, blank alternates 4'b0011/4'b0000 per tick.
- Simultaneous press_reset and tick_1hz in RUN at 00:09 -> 00:00, state IDLE, running = 0.
- rst pulled low mid-RUN at 12:34 -> all outputs 0 asynchronously; after release, ticks ignored until a pause press.

Source files
------------

// File: rtl/stopwatch_pkg.sv
//------------------------------------------------------------------------------
// Module  : stopwatch_pkg
// Brief   : Shared state encoding, BCD limits and blank masks for the stopwatch.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_ADJUST = 2'd3
  } state_t;

  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [7:0] MIN_MAX   = 8'h99;
  localparam logic [3:0] BLANK_MIN = 4'b1100;
  localparam logic [3:0] BLANK_SEC = 4'b0011;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//------------------------------------------------------------------------------
// Module  : btn_debounce
// Brief   : 2-flop synchronizer, stable-count filter and rising-edge press pulse.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam logic [DB_W-1:0] C_CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      r_sync;
  logic [DB_W-1:0] r_cnt;
  logic            r_level;
  logic            r_press;

  // The press pulse is raised in the same cycle the filtered level flips high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_raw};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_press <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// Module  : stopwatch_ctrl
// Brief   : Run/pause/adjust sequencer owning the BCD mm:ss count and blink mask.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [3:0] blank,
  output logic       running
);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return v + 8'd1;
  endfunction

  logic       w_press_pause;
  logic       w_press_reset;
  logic [1:0] r_adj_sync;
  logic [1:0] r_sel_sync;
  logic       w_adj;
  logic       w_sel;

  state_t     r_state;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic       r_blink;
  logic [3:0] r_blank;
  logic       r_running;

  state_t     w_state_nxt;
  logic [7:0] w_min_nxt;
  logic [7:0] w_sec_nxt;
  logic       w_blink_nxt;
  logic [3:0] w_blank_nxt;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_pause (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_pause),
    .press   (w_press_pause)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_reset (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_reset),
    .press   (w_press_reset)
  );

  assign w_adj = r_adj_sync[1];
  assign w_sel = r_sel_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adj_sync <= 2'b00;
      r_sel_sync <= 2'b00;
      r_state    <= ST_IDLE;
      r_min      <= 8'h00;
      r_sec      <= 8'h00;
      r_blink    <= 1'b0;
      r_blank    <= 4'b0000;
      r_running  <= 1'b0;
    end else begin
      r_adj_sync <= {r_adj_sync[0], sw_adj};
      r_sel_sync <= {r_sel_sync[0], sw_sel};
      r_state    <= w_state_nxt;
      r_min      <= w_min_nxt;
      r_sec      <= w_sec_nxt;
      r_blink    <= w_blink_nxt;
      r_blank    <= w_blank_nxt;
      r_running  <= (w_state_nxt == ST_RUN);
    end
  end

  // Priority: clear button, then adjust switch level, then pause, then ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_blink_nxt = r_blink;
    if (w_press_reset) begin
      w_min_nxt = 8'h00;
      w_sec_nxt = 8'h00;
      if (r_state != ST_ADJUST) begin
        w_state_nxt = ST_IDLE;
        w_blink_nxt = 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_min_nxt = 8'h00;
          w_sec_nxt = 8'h00;
          if (w_adj)              w_state_nxt = ST_ADJUST;
          else if (w_press_pause) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (w_adj) begin
            w_state_nxt = ST_ADJUST;
          end else begin
            if (tick_1hz) begin
              w_sec_nxt = bcd_inc(r_sec, SEC_MAX);
              if (r_sec == SEC_MAX) w_min_nxt = bcd_inc(r_min, MIN_MAX);
            end
            if (w_press_pause) w_state_nxt = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (w_adj)              w_state_nxt = ST_ADJUST;
          else if (w_press_pause) w_state_nxt = ST_RUN;
        end
        ST_ADJUST: begin
          if (!w_adj) begin
            w_state_nxt = ST_PAUSED;
            w_blink_nxt = 1'b0;
          end else if (tick_2hz) begin
            w_blink_nxt = ~r_blink;
            // Step only on the 1->0 blink transition, halving the 2 Hz rate.
            if (r_blink) begin
              if (w_sel) w_sec_nxt = bcd_inc(r_sec, SEC_MAX);
              else       w_min_nxt = bcd_inc(r_min, MIN_MAX);
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    w_blank_nxt = 4'b0000;
    if (w_state_nxt == ST_ADJUST && w_blink_nxt)
      w_blank_nxt = w_sel ? BLANK_SEC : BLANK_MIN;
  end

  assign minutes = r_min;
  assign seconds = r_sec;
  assign blank   = r_blank;
  assign running = r_running;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_stopwatch_ctrl
// Brief   : Self-checking bench for stopwatch_ctrl against a transaction-level model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

  localparam int DB_CYCLES = 4;
  localparam int DB_W      = 3;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       tick_1hz  = 1'b0;
  logic       tick_2hz  = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_reset = 1'b0;
  logic       sw_adj    = 1'b0;
  logic       sw_sel    = 1'b0;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic [3:0] blank;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;
  int run_changes = 0;
  logic prev_running = 1'b0;

  stopwatch_ctrl #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
    .btn_pause (btn_pause),
    .btn_reset (btn_reset),
    .sw_adj    (sw_adj),
    .sw_sel    (sw_sel),
    .minutes   (minutes),
    .seconds   (seconds),
    .blank     (blank),
    .running   (running)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer time and a mode code.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_ADJUST = 3;
  int m_min = 0, m_sec = 0, m_state = M_IDLE;
  bit m_blink = 0, m_adj = 0, m_sel = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic logic [3:0] model_blank();
    if (m_state == M_ADJUST && m_blink) return m_sel ? 4'b0011 : 4'b1100;
    return 4'b0000;
  endfunction

  task automatic model_settle();
    if (m_adj && m_state != M_ADJUST) m_state = M_ADJUST;
    else if (!m_adj && m_state == M_ADJUST) begin
      m_state = M_PAUSED;
      m_blink = 0;
    end
  endtask

  task automatic model_tick1();
    if (m_state == M_RUN) begin
      m_sec++;
      if (m_sec == 60) begin
        m_sec = 0;
        m_min = (m_min + 1) % 100;
      end
    end
  endtask

  task automatic model_tick2();
    if (m_state == M_ADJUST) begin
      m_blink = !m_blink;
      if (!m_blink) begin
        if (m_sel) m_sec = (m_sec + 1) % 60;
        else       m_min = (m_min + 1) % 100;
      end
    end
  endtask

  task automatic model_pause();
    if (m_state == M_IDLE || m_state == M_PAUSED) m_state = M_RUN;
    else if (m_state == M_RUN) m_state = M_PAUSED;
  endtask

  task automatic model_reset();
    m_min = 0;
    m_sec = 0;
    if (m_state != M_ADJUST) begin
      m_state = M_IDLE;
      m_blink = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".min"}, 32'(minutes), 32'(to_bcd(m_min)));
    chk({tag, ".sec"}, 32'(seconds), 32'(to_bcd(m_sec)));
    chk({tag, ".blank"}, 32'(blank), 32'(model_blank()));
    chk({tag, ".run"}, 32'(running), 32'(m_state == M_RUN));
  endtask

  // One clock; also watches the BCD invariant and counts running edges.
  task automatic step();
    logic ok;
    @(posedge clk);
    #1;
    if (rst) begin
      ok = (minutes[7:4] <= 4'd9) && (minutes[3:0] <= 4'd9) &&
           (seconds[7:4] <= 4'd5) && (seconds[3:0] <= 4'd9);
      chk("bcd_inv", 32'(ok), 32'd1);
    end
    if (running !== prev_running) run_changes++;
    prev_running = running;
  endtask

  task automatic do_tick(input bit t1, input bit t2);
    tick_1hz = t1;
    tick_2hz = t2;
    step();
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    if (t1) model_tick1();
    if (t2) model_tick2();
    step();
  endtask

  task automatic press(input bit is_reset);
    if (is_reset) btn_reset = 1'b1; else btn_pause = 1'b1;
    repeat (DB_CYCLES + 8) step();
    btn_reset = 1'b0;
    btn_pause = 1'b0;
    repeat (DB_CYCLES + 8) step();
    if (is_reset) model_reset(); else model_pause();
  endtask

  // Press whose debounced pulse lands in the same cycle as a tick_1hz.
  task automatic press_with_tick(input bit is_reset);
    if (is_reset) btn_reset = 1'b1; else btn_pause = 1'b1;
    repeat (DB_CYCLES + 2) step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    repeat (6) step();
    btn_reset = 1'b0;
    btn_pause = 1'b0;
    repeat (DB_CYCLES + 8) step();
    if (is_reset) model_reset();
    else begin
      model_tick1();
      model_pause();
    end
  endtask

  task automatic set_adj(input bit v);
    sw_adj = v;
    m_adj  = v;
    repeat (4) step();
    model_settle();
  endtask

  task automatic set_sel(input bit v);
    sw_sel = v;
    m_sel  = v;
    repeat (4) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) step();
    check_all("reset");
    rst = 1'b1;
    step();

    // Run 75 seconds
    press(1'b0);
    repeat (75) do_tick(1'b1, 1'b0);
    check_all("run75");
    chk("run75.min_abs", 32'(minutes), 32'h01);
    chk("run75.sec_abs", 32'(seconds), 32'h15);

    // Preload 99:59 through adjust, then wrap
    set_sel(1'b0);
    set_adj(1'b1);
    repeat (196) do_tick(1'b0, 1'b1);
    set_sel(1'b1);
    repeat (88) do_tick(1'b0, 1'b1);
    check_all("preload");
    set_adj(1'b0);
    press(1'b0);
    chk("preload.min_abs", 32'(minutes), 32'h99);
    chk("preload.sec_abs", 32'(seconds), 32'h59);
    do_tick(1'b1, 1'b0);
    check_all("wrap");
    chk("wrap.abs", 32'({minutes, seconds, running}), 32'({16'h0000, 1'b1}));

    // Bouncing pause button
    press(1'b1);
    check_all("clr_idle");
    base = run_changes;
    for (int i = 0; i < 10; i++) begin
      btn_pause = ~btn_pause;
      repeat (2) step();
    end
    btn_pause = 1'b1;
    repeat (10) step();
    btn_pause = 1'b0;
    repeat (DB_CYCLES + 8) step();
    model_pause();
    chk("bounce.changes", 32'(run_changes - base), 32'd1);
    check_all("bounce");

    // Adjust seconds from 00:58
    repeat (58) do_tick(1'b1, 1'b0);
    press(1'b0);
    check_all("paused58");
    set_sel(1'b1);
    set_adj(1'b1);
    for (int i = 0; i < 8; i++) begin
      do_tick(1'b0, 1'b1);
      chk("adj.blank_abs", 32'(blank), (i % 2 == 0) ? 32'h3 : 32'h0);
      check_all("adj");
    end
    chk("adj.sec_abs", 32'(seconds), 32'h02);
    chk("adj.min_abs", 32'(minutes), 32'h00);
    set_adj(1'b0);
    check_all("adj_exit");

    // Clear coinciding with tick_1hz at 00:09
    press(1'b1);
    press(1'b0);
    repeat (9) do_tick(1'b1, 1'b0);
    check_all("run9");
    press_with_tick(1'b1);
    check_all("clr_tick");

    // Pause coinciding with tick_1hz: tick still counts
    press(1'b0);
    repeat (3) do_tick(1'b1, 1'b0);
    press_with_tick(1'b0);
    check_all("pause_tick");
    chk("pause_tick.sec_abs", 32'(seconds), 32'h04);

    // Asynchronous reset mid-run at 12:34
    press(1'b0);
    while (m_min * 60 + m_sec < 754) do_tick(1'b1, 1'b0);
    check_all("run1234");
    #3 rst = 1'b0;
    #1;
    chk("async_rst", 32'({minutes, seconds, blank, running}), 32'd0);
    m_min = 0; m_sec = 0; m_state = M_IDLE; m_blink = 0;
    repeat (3) step();
    rst = 1'b1;
    repeat (5) do_tick(1'b1, 1'b0);
    check_all("post_rst_idle");
    press(1'b0);
    do_tick(1'b1, 1'b0);
    check_all("post_rst_run");

    // Randomized operation sequence
    for (int op_i = 0; op_i < 40; op_i++) begin
      int op;
      op = $urandom_range(0, 6);
      case (op)
        0, 1: press(1'b0);
        2:    press(1'b1);
        3:    set_adj(!m_adj);
        4:    set_sel(!m_sel);
        default: begin
          int n;
          n = $urandom_range(1, 25);
          for (int k = 0; k < n; k++) begin
            bit t1, t2;
            t1 = 1'($urandom_range(0, 1));
            t2 = 1'($urandom_range(0, 1));
            if (!t1 && !t2) t1 = 1'b1;
            do_tick(t1, t2);
          end
        end
      endcase
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
